// File: rtl/ea_sequencer_if.sv
// Addressing-mode types and the requester/memory bus of the effective-address sequencer.
package ea_sequencer_pkg;
   typedef enum logic [3:0] {
      AM_IMP  = 4'h0,
      AM_ACC  = 4'h1,
      AM_IMM  = 4'h2,
      AM_ZP   = 4'h3,
      AM_ZPX  = 4'h4,
      AM_ZPY  = 4'h5,
      AM_ABS  = 4'h6,
      AM_ABSX = 4'h7,
      AM_ABSY = 4'h8,
      AM_IXID = 4'h9,
      AM_IDIX = 4'hA,
      AM_INDY = 4'hB,
      AM_REL  = 4'hC
   } addmod_t;

   typedef enum logic {
      RW_READ  = 1'b0,
      RW_WRITE = 1'b1
   } rw_t;
endpackage

interface ea_sequencer_if;
   import ea_sequencer_pkg::*;

   logic        start;
   addmod_t     mode;
   logic [15:0] pc;
   logic [7:0]  x;
   logic [7:0]  y;
   logic [7:0]  rdata;
   logic [15:0] mem_addr;
   logic        rd_en;
   logic        busy;
   logic        done;
   logic [15:0] ea;
   logic        page_cross;

   modport master (
      output start, mode, pc, x, y, rdata,
      input  mem_addr, rd_en, busy, done, ea, page_cross
   );

   modport slave (
      input  start, mode, pc, x, y, rdata,
      output mem_addr, rd_en, busy, done, ea, page_cross
   );
endinterface

// File: rtl/ea_sequencer.sv
// Effective-address sequencer: resolves a 6502-style operand address with one memory read per state.
// Optional EA_PAGE_PENALTY_EN adds a FIX dummy-read cycle when indexing crosses a page.
module ea_sequencer
   import ea_sequencer_pkg::*;
#(
   parameter logic [7:0] ZP_HI = 8'h00
) (
   input logic           clk,
   input logic           reset_n,
   ea_sequencer_if.slave bus
);

`ifdef EA_PAGE_PENALTY_EN
   localparam bit PenaltyEn = 1'b1;
`else
   localparam bit PenaltyEn = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_OP1, S_OP2, S_PTRLO, S_PTRHI, S_FIX, S_DONE
   } state_t;

   state_t      state;
   addmod_t     md;
   logic [15:0] pc_r;
   logic [15:0] ptr_r;
   logic [7:0]  x_r;
   logic [7:0]  y_r;
   logic [7:0]  lo_r;

   logic [7:0]  idx_c;
   logic [15:0] sum_c;
   logic        cross_c;

   // Indexed sum for the state whose read returns the high byte (OP2 or PTRHI).
   always_comb begin
      idx_c   = (md == AM_ABSY || md == AM_IDIX) ? y_r : x_r;
      sum_c   = {bus.rdata, lo_r} + {8'h00, idx_c};
      cross_c = (sum_c[15:8] != bus.rdata);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         md             <= AM_IMP;
         pc_r           <= '0;
         ptr_r          <= '0;
         x_r            <= '0;
         y_r            <= '0;
         lo_r           <= '0;
         bus.mem_addr   <= '0;
         bus.rd_en      <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.ea         <= '0;
         bus.page_cross <= 1'b0;
      end else begin
         bus.done     <= 1'b0;
         bus.rd_en    <= 1'b0;
         bus.mem_addr <= '0;
         bus.busy     <= 1'b1;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  md   <= bus.mode;
                  pc_r <= bus.pc;
                  x_r  <= bus.x;
                  y_r  <= bus.y;
                  case (bus.mode)
                     AM_IMM: begin
                        bus.ea         <= bus.pc;
                        bus.page_cross <= 1'b0;
                        bus.done       <= 1'b1;
                        state          <= S_DONE;
                     end
                     AM_ZP, AM_ZPX, AM_ZPY, AM_ABS, AM_ABSX, AM_ABSY,
                     AM_IXID, AM_IDIX, AM_INDY, AM_REL: begin
                        bus.rd_en    <= 1'b1;
                        bus.mem_addr <= bus.pc;
                        state        <= S_OP1;
                     end
                     default: begin
                        bus.ea         <= '0;
                        bus.page_cross <= 1'b0;
                        bus.done       <= 1'b1;
                        state          <= S_DONE;
                     end
                  endcase
               end else begin
                  bus.busy <= 1'b0;
               end
            end

            S_OP1: begin
               case (md)
                  AM_ZP, AM_ZPX, AM_ZPY: begin
                     bus.ea <= (md == AM_ZP)  ? {ZP_HI, bus.rdata} :
                               (md == AM_ZPX) ? {ZP_HI, 8'(bus.rdata + x_r)} :
                                                {ZP_HI, 8'(bus.rdata + y_r)};
                     bus.page_cross <= 1'b0;
                     bus.done       <= 1'b1;
                     state          <= S_DONE;
                  end
                  AM_IXID, AM_IDIX: begin
                     ptr_r        <= (md == AM_IXID) ? {ZP_HI, 8'(bus.rdata + x_r)} : {ZP_HI, bus.rdata};
                     bus.mem_addr <= (md == AM_IXID) ? {ZP_HI, 8'(bus.rdata + x_r)} : {ZP_HI, bus.rdata};
                     bus.rd_en    <= 1'b1;
                     state        <= S_PTRLO;
                  end
                  AM_REL: begin
                     bus.ea         <= pc_r + 16'd1 + {{8{bus.rdata[7]}}, bus.rdata};
                     bus.page_cross <= 1'b0;
                     bus.done       <= 1'b1;
                     state          <= S_DONE;
                  end
                  default: begin
                     lo_r         <= bus.rdata;
                     bus.mem_addr <= pc_r + 16'd1;
                     bus.rd_en    <= 1'b1;
                     state        <= S_OP2;
                  end
               endcase
            end

            S_OP2: begin
               case (md)
                  AM_ABSX, AM_ABSY: begin
                     bus.ea         <= sum_c;
                     bus.page_cross <= cross_c;
                     if (PenaltyEn && cross_c) begin
                        bus.mem_addr <= {bus.rdata, 8'(lo_r + idx_c)};
                        bus.rd_en    <= 1'b1;
                        state        <= S_FIX;
                     end else begin
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                     end
                  end
                  AM_INDY: begin
                     ptr_r        <= {bus.rdata, lo_r};
                     bus.mem_addr <= {bus.rdata, lo_r};
                     bus.rd_en    <= 1'b1;
                     state        <= S_PTRLO;
                  end
                  default: begin
                     bus.ea         <= {bus.rdata, lo_r};
                     bus.page_cross <= 1'b0;
                     bus.done       <= 1'b1;
                     state          <= S_DONE;
                  end
               endcase
            end

            // Pointer high byte never carries into the pointer's page.
            S_PTRLO: begin
               lo_r         <= bus.rdata;
               bus.mem_addr <= {ptr_r[15:8], 8'(ptr_r[7:0] + 8'd1)};
               bus.rd_en    <= 1'b1;
               state        <= S_PTRHI;
            end

            S_PTRHI: begin
               if (md == AM_IDIX) begin
                  bus.ea         <= sum_c;
                  bus.page_cross <= cross_c;
                  if (PenaltyEn && cross_c) begin
                     bus.mem_addr <= {bus.rdata, 8'(lo_r + idx_c)};
                     bus.rd_en    <= 1'b1;
                     state        <= S_FIX;
                  end else begin
                     bus.done <= 1'b1;
                     state    <= S_DONE;
                  end
               end else begin
                  bus.ea         <= {bus.rdata, lo_r};
                  bus.page_cross <= 1'b0;
                  bus.done       <= 1'b1;
                  state          <= S_DONE;
               end
            end

            S_FIX: begin
               bus.done <= 1'b1;
               state    <= S_DONE;
            end

            S_DONE: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end

            default: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
